// File: rtl/prio_arbiter.sv
// prio_arbiter: registered fixed/round-robin priority arbiter with optional hold limit
module prio_arbiter #(
   parameter int N        = 7,
   parameter int W        = 3,
   parameter int HOLD     = 1,
   parameter int MAX_HOLD = 0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         mode,
   input  logic [N:1]   req,
   output logic [N:1]   gnt,
   output logic [W-1:0] gnt_idx,
   output logic         gnt_vld
);
   localparam int CW = $clog2(MAX_HOLD + 2);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t        state;
   logic [W-1:0]  ptr;
   logic [CW-1:0] cnt;
   logic [N:0]    req_ext;
   logic [N:1]    masked;
   logic [W-1:0]  win;
   logic [W-1:0]  sel;
   logic [N:0]    oh;
   logic          held;
   logic          expire;
   logic          arb;

   // First asserted request in search order; 0 when nothing is requesting.
   // Scanning backwards lets the earliest candidate overwrite later ones.
   function automatic logic [W-1:0] pick(input logic [N:1] r, input logic [W-1:0] p, input logic rr);
      int c;
      pick = '0;
      for (int i = N; i >= 1; i--) begin
         c = rr ? ((int'(p) + i - 1) % N) + 1 : i;
         if (r[W'(c)]) pick = W'(c);
      end
   endfunction

   // Winner selection; on hold expiry the current owner is masked, and it
   // is re-granted only when nobody else is waiting.
   always_comb begin
      req_ext = {req, 1'b0};
      held    = (HOLD != 0) && req_ext[gnt_idx];
      expire  = held && (MAX_HOLD != 0) && (cnt == CW'(MAX_HOLD - 1));
      masked  = expire ? req & ~gnt : req;
      win     = pick(masked, ptr, mode);
      sel     = (expire && win == '0) ? gnt_idx : win;
      arb     = (state == IDLE) || !held || expire;
      oh      = (N + 1)'(1) << sel;
   end

   // Grant state machine with registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         gnt     <= '0;
         gnt_idx <= '0;
         gnt_vld <= 1'b0;
         ptr     <= W'(N);
         cnt     <= '0;
      end else if (arb) begin
         state   <= (sel != '0) ? GRANT : IDLE;
         gnt     <= oh[N:1];
         gnt_idx <= sel;
         gnt_vld <= sel != '0;
         ptr     <= (sel != '0) ? sel : ptr;
         cnt     <= '0;
      end else begin
         cnt <= (cnt == CW'(MAX_HOLD)) ? cnt : cnt + 1'b1;
      end
   end
endmodule

// File: tb/tb_prio_arbiter.sv
// tb_prio_arbiter: directed checks of priority, round-robin, hold limit and async reset
module tb_prio_arbiter;
   logic       clk = 0;
   logic       rst = 1;
   logic       mode = 0;
   logic [7:1] r0 = 0, r1 = 0, r2 = 0;
   logic [7:1] g0, g1, g2;
   logic [2:0] i0, i1, i2;
   logic       v0, v1, v2;
   int         n_cmp = 0, n_bad = 0;

   prio_arbiter #(.N(7), .W(3), .HOLD(1), .MAX_HOLD(0)) d0 (
      .clk(clk), .rst(rst), .mode(mode), .req(r0), .gnt(g0), .gnt_idx(i0), .gnt_vld(v0));
   prio_arbiter #(.N(7), .W(3), .HOLD(0), .MAX_HOLD(0)) d1 (
      .clk(clk), .rst(rst), .mode(mode), .req(r1), .gnt(g1), .gnt_idx(i1), .gnt_vld(v1));
   prio_arbiter #(.N(7), .W(3), .HOLD(1), .MAX_HOLD(4)) d2 (
      .clk(clk), .rst(rst), .mode(mode), .req(r2), .gnt(g2), .gnt_idx(i2), .gnt_vld(v2));

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      n_cmp++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #12;
      check("rst_g0", g0, 0);
      check("rst_i0", i0, 0);
      check("rst_v0", v0, 0);
      check("rst_i1", i1, 0);
      check("rst_v2", v2, 0);
      rst = 0;
      // fixed priority, gapless handover
      r0 = 7'b0101100;
      step();
      check("fix_idx", i0, 3);
      check("fix_gnt", g0, 7'b0000100);
      check("fix_vld", v0, 1);
      r0 = 7'b0101000;
      step();
      check("hand_idx", i0, 4);
      check("hand_vld", v0, 1);
      r0 = 0;
      step();
      check("idle_vld", v0, 0);
      // round robin, re-arbitrate every cycle
      mode = 1;
      r1 = 7'h7f;
      for (int k = 0; k < 8; k++) begin
         step();
         check("rr_idx", i1, (k % 7) + 1);
         check("rr_gnt", g1, 1 << (k % 7));
      end
      r1 = 0;
      // hold limit alternation between channels 2 and 5
      r2 = 7'b0010010;
      for (int k = 0; k < 16; k++) begin
         step();
         check("tmo_idx", i2, ((k / 4) % 2) ? 5 : 2);
         check("tmo_vld", v2, 1);
      end
      // lone requester keeps the grant indefinitely
      r2 = 7'b0000010;
      for (int k = 0; k < 12; k++) begin
         step();
         check("solo_idx", i2, 2);
         check("solo_vld", v2, 1);
      end
      r2 = 0;
      // mode switch while holding channel 6
      mode = 0;
      r0 = 7'b1100000;
      step();
      check("ms_fix", i0, 6);
      mode = 1;
      r0 = 7'b1100001;
      step();
      check("ms_keep1", i0, 6);
      step();
      check("ms_keep2", i0, 6);
      r0 = 7'b1000001;
      step();
      check("ms_rr", i0, 7);
      // asynchronous reset mid-grant
      r0 = 7'b0010000;
      step();
      check("ar_pre", i0, 5);
      #2 rst = 1;
      #1;
      check("ar_idx", i0, 0);
      check("ar_gnt", g0, 0);
      check("ar_vld", v0, 0);
      r0 = 7'b1000000;
      #1 rst = 0;
      step();
      check("ar_post", i0, 7);
      check("ar_post_gnt", g0, 7'b1000000);
      // pointer restarts from N after reset
      r0 = 7'b0010000;
      step();
      check("pr_pre", i0, 5);
      #2 rst = 1;
      r0 = 7'b1000100;
      #2 rst = 0;
      step();
      check("pr_ptr", i0, 3);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
